// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// General-purpose register file with two registered read ports, one write-back
// port (with link-register redirect) and a per-register pending-write
// scoreboard used by decode for RAW hazard detection.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   rs_addr, rt_addr    read indices
//   rs_data, rt_data    registered read data (1-cycle latency)
//   rs_busy, rt_busy    registered: read register has writes outstanding
//   iss_en, iss_addr    issue request marking iss_addr pending
//   iss_ready           combinational: issue accepted this cycle
//   wr_en, wr_addr,
//   wr_link, wr_data    write-back (wr_link redirects to LINK_REG)
//   sb_err              sticky: write-back to a register with zero pending
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 2,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_link,
    input  logic [DATA_W-1:0] wr_data,
    output logic              sb_err
);

    localparam int               NUM_REGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [DATA_W-1:0] regs_r     [NUM_REGS];
    logic [CNT_W-1:0]  cnt_r      [NUM_REGS];
    logic [CNT_W-1:0]  cnt_next_s [NUM_REGS];

    logic [DATA_W-1:0] rs_data_r, rt_data_r;
    logic              rs_busy_r, rt_busy_r;
    logic              sb_err_r;

    logic [ADDR_W-1:0] wa_s;
    logic              inc_s, dec_s, same_s, err_set_s, iss_ready_s;
    logic [DATA_W-1:0] rs_data_s, rt_data_s;

    // Register 0 never receives a write or an issue, so it stays zero.
    assign wa_s        = wr_link ? ADDR_W'(LINK_REG) : wr_addr;
    assign iss_ready_s = (iss_addr == {ADDR_W{1'b0}}) || (cnt_r[iss_addr] != CNT_MAX);
    assign inc_s       = iss_en && iss_ready_s && (iss_addr != {ADDR_W{1'b0}});
    assign dec_s       = wr_en && (wa_s != {ADDR_W{1'b0}});
    // Issue and write-back on one register cancel; no underflow error then.
    assign same_s      = inc_s && dec_s && (iss_addr == wa_s);
    assign err_set_s   = dec_s && !same_s && (cnt_r[wa_s] == {CNT_W{1'b0}});

    // Next-state scoreboard counters: saturating at 0 on decrement; increment
    // cannot overflow because iss_ready gates it.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (inc_s && !same_s && (iss_addr == ADDR_W'(i))) begin
                cnt_next_s[i] = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (dec_s && !same_s && (wa_s == ADDR_W'(i)) &&
                         (cnt_r[i] != {CNT_W{1'b0}})) begin
                cnt_next_s[i] = cnt_r[i] - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end
    end

    // Read-data selection, with optional same-edge forwarding of write data.
    always_comb begin
        rs_data_s = regs_r[rs_addr];
        rt_data_s = regs_r[rt_addr];
        if (rs_addr == {ADDR_W{1'b0}}) begin
            rs_data_s = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && dec_s && (wa_s == rs_addr)) begin
            rs_data_s = wr_data;
        end else begin
            rs_data_s = regs_r[rs_addr];
        end
        if (rt_addr == {ADDR_W{1'b0}}) begin
            rt_data_s = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && dec_s && (wa_s == rt_addr)) begin
            rt_data_s = wr_data;
        end else begin
            rt_data_s = regs_r[rt_addr];
        end
    end

    // Register array write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (dec_s) begin
            regs_r[wa_s] <= wr_data;
        end
    end

    // Scoreboard counter update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    // Registered read ports, busy flags (post-update counts) and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_data_r <= {DATA_W{1'b0}};
            rt_data_r <= {DATA_W{1'b0}};
            rs_busy_r <= 1'b0;
            rt_busy_r <= 1'b0;
            sb_err_r  <= 1'b0;
        end else begin
            rs_data_r <= rs_data_s;
            rt_data_r <= rt_data_s;
            rs_busy_r <= (cnt_next_s[rs_addr] != {CNT_W{1'b0}});
            rt_busy_r <= (cnt_next_s[rt_addr] != {CNT_W{1'b0}});
            sb_err_r  <= sb_err_r | err_set_s;
        end
    end

    assign rs_data   = rs_data_r;
    assign rt_data   = rt_data_r;
    assign rs_busy   = rs_busy_r;
    assign rt_busy   = rt_busy_r;
    assign sb_err    = sb_err_r;
    assign iss_ready = iss_ready_s;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Table-driven bench for regfile_sb. Two instances share all inputs: dut
// (BYPASS=1) and dut_nb (BYPASS=0). Each vector's expected outputs are queued
// when driven and compared after the following rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  rs_addr = 5'd0, rt_addr = 5'd0, iss_addr = 5'd0, wr_addr = 5'd0;
    logic        iss_en = 1'b0, wr_en = 1'b0, wr_link = 1'b0;
    logic [31:0] wr_data = 32'h0;

    logic [31:0] rs_data, rt_data, rs_data_nb, rt_data_nb;
    logic        rs_busy, rt_busy, iss_ready, sb_err;
    logic        rs_busy_nb, rt_busy_nb, iss_ready_nb, sb_err_nb;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic        ie;
        logic [4:0]  ia;
        logic        we;
        logic        wl;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        e_rdy;
        logic [31:0] e_rs;
        logic        e_rsb;
        logic [31:0] e_rt;
        logic        e_rtb;
        logic        e_err;
        logic [31:0] e_rs_nb;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    regfile_sb #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_link(wr_link), .wr_data(wr_data),
        .sb_err(sb_err)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data_nb), .rt_data(rt_data_nb), .rs_busy(rs_busy_nb), .rt_busy(rt_busy_nb),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_link(wr_link), .wr_data(wr_data),
        .sb_err(sb_err_nb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic ie, input logic [4:0] ia,
                       input logic we, input logic wl, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic e_rdy, input logic [31:0] e_rs, input logic e_rsb,
                       input logic [31:0] e_rt, input logic e_rtb, input logic e_err,
                       input logic [31:0] e_rs_nb);
        vec_t v;
        v.name = name; v.ie = ie; v.ia = ia; v.we = we; v.wl = wl; v.wa = wa;
        v.wd = wd; v.rs = rs; v.rt = rt; v.e_rdy = e_rdy; v.e_rs = e_rs;
        v.e_rsb = e_rsb; v.e_rt = e_rt; v.e_rtb = e_rtb; v.e_err = e_err;
        v.e_rs_nb = e_rs_nb;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        iss_en = v.ie; iss_addr = v.ia; wr_en = v.we; wr_link = v.wl;
        wr_addr = v.wa; wr_data = v.wd; rs_addr = v.rs; rt_addr = v.rt;
        #1;
        chk({v.name, ".iss_ready"}, {31'd0, iss_ready}, {31'd0, v.e_rdy});
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.name, ".rs_data"},    rs_data,             e.e_rs);
        chk({e.name, ".rs_busy"},    {31'd0, rs_busy},    {31'd0, e.e_rsb});
        chk({e.name, ".rt_data"},    rt_data,             e.e_rt);
        chk({e.name, ".rt_busy"},    {31'd0, rt_busy},    {31'd0, e.e_rtb});
        chk({e.name, ".sb_err"},     {31'd0, sb_err},     {31'd0, e.e_err});
        chk({e.name, ".rs_data_nb"}, rs_data_nb,          e.e_rs_nb);
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".rs_data"},    rs_data,           32'h0);
        chk({name, ".rt_data"},    rt_data,           32'h0);
        chk({name, ".rs_busy"},    {31'd0, rs_busy},  32'h0);
        chk({name, ".rt_busy"},    {31'd0, rt_busy},  32'h0);
        chk({name, ".sb_err"},     {31'd0, sb_err},   32'h0);
        chk({name, ".rs_data_nb"}, rs_data_nb,        32'h0);
        chk({name, ".iss_ready"},  {31'd0, iss_ready}, 32'h1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //   name            ie ia  we wl wa  wd            rs  rt  rdy rs            rsb rt            rtb err rs_nb
        add("iss_r3",        1, 3,  0, 0, 0,  32'h0,        3,  3,  1,  32'h0,        1,  32'h0,        1,  0,  32'h0);
        add("bypass_r3",     0, 3,  1, 0, 3,  32'hDEADBEEF, 3,  0,  1,  32'hDEADBEEF, 0,  32'h0,        0,  0,  32'h0);
        add("nb_new_r3",     0, 0,  0, 0, 0,  32'h0,        3,  3,  1,  32'hDEADBEEF, 0,  32'hDEADBEEF, 0,  0,  32'hDEADBEEF);
        add("iss_r31",       1, 31, 0, 0, 0,  32'h0,        9,  31, 1,  32'h0,        0,  32'h0,        1,  0,  32'h0);
        add("link_wr",       0, 0,  1, 1, 9,  32'h400,      9,  31, 1,  32'h0,        0,  32'h400,      0,  0,  32'h0);
        add("link_rd",       0, 0,  0, 0, 0,  32'h0,        9,  31, 1,  32'h0,        0,  32'h400,      0,  0,  32'h0);
        add("wr_r0",         0, 0,  1, 0, 0,  32'h55,       0,  0,  1,  32'h0,        0,  32'h0,        0,  0,  32'h0);
        add("rd_r0",         0, 0,  0, 0, 0,  32'h0,        0,  0,  1,  32'h0,        0,  32'h0,        0,  0,  32'h0);
        add("iss_r4_a",      1, 4,  0, 0, 0,  32'h0,        4,  4,  1,  32'h0,        1,  32'h0,        1,  0,  32'h0);
        add("iss_r4_b",      1, 4,  0, 0, 0,  32'h0,        4,  4,  1,  32'h0,        1,  32'h0,        1,  0,  32'h0);
        add("iss_r4_c",      1, 4,  0, 0, 0,  32'h0,        4,  4,  1,  32'h0,        1,  32'h0,        1,  0,  32'h0);
        add("iss_r4_held",   1, 4,  0, 0, 0,  32'h0,        4,  4,  0,  32'h0,        1,  32'h0,        1,  0,  32'h0);
        add("wb_r4_1",       1, 4,  1, 0, 4,  32'h11,       4,  4,  0,  32'h11,       1,  32'h11,       1,  0,  32'h0);
        add("r4_ready_cnt2", 0, 4,  0, 0, 0,  32'h0,        4,  4,  1,  32'h11,       1,  32'h11,       1,  0,  32'h11);
        add("wb_r4_2",       0, 4,  1, 0, 4,  32'h22,       4,  4,  1,  32'h22,       1,  32'h22,       1,  0,  32'h11);
        add("wb_r4_3",       0, 0,  1, 0, 4,  32'h33,       4,  4,  1,  32'h33,       0,  32'h33,       0,  0,  32'h22);
        add("iss_r6",        1, 6,  0, 0, 0,  32'h0,        6,  6,  1,  32'h0,        1,  32'h0,        1,  0,  32'h0);
        add("iss_wb_r6_c1",  1, 6,  1, 0, 6,  32'h66,       6,  6,  1,  32'h66,       1,  32'h66,       1,  0,  32'h0);
        add("wb_r6",         0, 0,  1, 0, 6,  32'h67,       6,  6,  1,  32'h67,       0,  32'h67,       0,  0,  32'h66);
        add("iss_wb_r6_c0",  1, 6,  1, 0, 6,  32'h68,       6,  6,  1,  32'h68,       0,  32'h68,       0,  0,  32'h67);
        add("iss_r7",        1, 7,  0, 0, 0,  32'h0,        7,  6,  1,  32'h0,        1,  32'h68,       0,  0,  32'h0);
        add("iss10_wb7",     1, 10, 1, 0, 7,  32'h77,       7,  10, 1,  32'h77,       0,  32'h0,        1,  0,  32'h0);
        add("err_r8",        0, 0,  1, 0, 8,  32'h88,       8,  10, 1,  32'h88,       0,  32'h0,        1,  1,  32'h0);
        add("err_sticky_a",  0, 0,  1, 0, 10, 32'hA0,       8,  10, 1,  32'h88,       0,  32'hA0,       0,  1,  32'h88);
        add("err_sticky_b",  1, 12, 0, 0, 0,  32'h0,        12, 8,  1,  32'h0,        1,  32'h88,       0,  1,  32'h0);
        add("iss_r5_a",      1, 5,  0, 0, 0,  32'h0,        5,  5,  1,  32'h0,        1,  32'h0,        1,  1,  32'h0);
        add("iss_r5_b",      1, 5,  0, 0, 0,  32'h0,        5,  5,  1,  32'h0,        1,  32'h0,        1,  1,  32'h0);
        add("iss_r5_c",      1, 5,  0, 0, 0,  32'h0,        5,  5,  1,  32'h0,        1,  32'h0,        1,  1,  32'h0);
        add("wb_r5",         0, 0,  1, 0, 5,  32'h7,        5,  5,  1,  32'h7,        1,  32'h7,        1,  1,  32'h0);
        run_table();

        // Reset in the middle of traffic: cnt[5]=2, regs[5]=7, sb_err=1.
        @(negedge clk);
        iss_en = 1'b0; iss_addr = 5'd5; wr_en = 1'b0; wr_link = 1'b0;
        wr_addr = 5'd0; wr_data = 32'h0; rs_addr = 5'd5; rt_addr = 5'd12;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        #1 rst_n = 1'b1;

        add("rst_rd_r5",     0, 5,  0, 0, 0,  32'h0,        5,  12, 1,  32'h0,        0,  32'h0,        0,  0,  32'h0);
        add("rst_wb_r5",     0, 0,  1, 0, 5,  32'h9,        5,  0,  1,  32'h9,        0,  32'h0,        0,  1,  32'h0);
        run_table();

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
